// File: rtl/sdram_responder.sv
// SDR SDRAM device model (x16, 4 banks) answering a controller's command stream.
// Tracks open rows per bank, stores data internally and returns reads at CAS latency 2 or 3.
module sdram_responder #(
  parameter int ROW_BITS     = 4,
  parameter int COL_BITS     = 8,
  parameter int REFRESH_INIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [12:0] a,
  input  logic [1:0]  ba,
  input  logic [1:0]  dm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic [7:0]  refresh_count,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] INIT_REFS = 8'(REFRESH_INIT);

  localparam logic [2:0] E_DBL_ACT = 3'd1;
  localparam logic [2:0] E_CLOSED  = 3'd2;
  localparam logic [2:0] E_OPEN    = 3'd3;
  localparam logic [2:0] E_MODE    = 3'd4;
  localparam logic [2:0] E_BUS     = 3'd5;
  localparam logic [2:0] E_INIT    = 3'd6;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_MRS, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD
  } cmd_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cmd_t                cmd;
  logic [3:0]          bank_open, bank_open_nxt;
  logic [ROW_BITS-1:0] open_row [4];
  logic                row_load;
  logic                cl3, cl3_nxt;
  logic                pall_seen, pall_nxt;
  logic [7:0]          init_cnt, init_cnt_nxt;
  logic [7:0]          ref_nxt;
  logic                init_nxt;
  logic                err_hit;
  logic [2:0]          err_val;
  logic                wr_en, rd_vld;
  logic                in_flight;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   data_p0, data_p1;
  logic                vld_p0, vld_p1;
  logic                out_vld;
  logic [DATA_W-1:0]   out_data;
  logic                unused_a;

  assign unused_a  = ^{a[12:11], a[9:8]};
  assign addr      = {ba, open_row[ba], a[COL_BITS-1:0]};
  assign in_flight = vld_p0 | (cl3 & vld_p1) | dq_oe;
  assign out_vld   = cl3 ? vld_p1 : vld_p0;
  assign out_data  = cl3 ? data_p1 : data_p0;

  always_comb begin
    cmd = CMD_NOP;
    if (cke && !cs_n && !reset) begin
      unique case ({ras_n, cas_n, we_n})
        3'b000:  cmd = CMD_MRS;
        3'b001:  cmd = CMD_REF;
        3'b010:  cmd = CMD_PRE;
        3'b011:  cmd = CMD_ACT;
        3'b100:  cmd = CMD_WR;
        3'b101:  cmd = CMD_RD;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  always_comb begin
    bank_open_nxt = bank_open;
    row_load      = 1'b0;
    cl3_nxt       = cl3;
    pall_nxt      = pall_seen;
    init_cnt_nxt  = init_cnt;
    ref_nxt       = refresh_count;
    err_hit       = 1'b0;
    err_val       = err_code;
    wr_en         = 1'b0;
    rd_vld        = 1'b0;
    init_nxt      = init_done;
    unique case (cmd)
      CMD_ACT: begin
        if (!init_done) begin
          err_hit = 1'b1; err_val = E_INIT;
        end else if (bank_open[ba]) begin
          err_hit = 1'b1; err_val = E_DBL_ACT;
        end else begin
          bank_open_nxt[ba] = 1'b1;
          row_load          = 1'b1;
        end
      end
      CMD_WR: begin
        if (!init_done) begin
          err_hit = 1'b1; err_val = E_INIT;
        end else if (!bank_open[ba]) begin
          err_hit = 1'b1; err_val = E_CLOSED;
        end else begin
          wr_en = 1'b1;
          if (in_flight) begin
            err_hit = 1'b1; err_val = E_BUS;
          end
          if (a[10]) bank_open_nxt[ba] = 1'b0;
        end
      end
      CMD_RD: begin
        if (!init_done) begin
          err_hit = 1'b1; err_val = E_INIT;
        end else if (!bank_open[ba]) begin
          err_hit = 1'b1; err_val = E_CLOSED;
        end else begin
          rd_vld = (dm != 2'b11);
          if (a[10]) bank_open_nxt[ba] = 1'b0;
        end
      end
      CMD_PRE: begin
        if (a[10]) begin
          bank_open_nxt = 4'b0000;
          pall_nxt      = 1'b1;
        end else begin
          bank_open_nxt[ba] = 1'b0;
        end
      end
      CMD_REF: begin
        if (bank_open != 4'b0000) begin
          err_hit = 1'b1; err_val = E_OPEN;
        end else begin
          ref_nxt = sat_inc(refresh_count);
          if (pall_seen) init_cnt_nxt = sat_inc(init_cnt);
        end
      end
      CMD_MRS: begin
        if (bank_open != 4'b0000) begin
          err_hit = 1'b1; err_val = E_OPEN;
        end else begin
          if (a[6:4] == 3'd2)      cl3_nxt = 1'b0;
          else if (a[6:4] == 3'd3) cl3_nxt = 1'b1;
          else begin
            err_hit = 1'b1; err_val = E_MODE;
          end
          if (a[2:0] != 3'b000) begin
            err_hit = 1'b1; err_val = E_MODE;
          end
        end
      end
      default: ;
    endcase
    if (pall_nxt && (init_cnt_nxt >= INIT_REFS)) init_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open     <= 4'b0000;
      cl3           <= 1'b0;
      pall_seen     <= 1'b0;
      init_cnt      <= 8'd0;
      init_done     <= 1'b0;
      refresh_count <= 8'd0;
      err           <= 1'b0;
      err_code      <= 3'd0;
    end else begin
      bank_open     <= bank_open_nxt;
      cl3           <= cl3_nxt;
      pall_seen     <= pall_nxt;
      init_cnt      <= init_cnt_nxt;
      init_done     <= init_nxt;
      refresh_count <= ref_nxt;
      if (err_hit) begin
        err      <= 1'b1;
        err_code <= err_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (row_load) open_row[ba] <= a[ROW_BITS-1:0];
  end

  // Stage p0: array fetched on the READ edge; writes land on the WRITE edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!dm[0]) mem[addr][7:0]  <= dq_in[7:0];
      if (!dm[1]) mem[addr][15:8] <= dq_in[15:8];
    end
    if (rd_vld) data_p0 <= mem[addr];
    data_p1 <= data_p0;
  end

  // Stage p1 / bus: CL2 drives from p0, CL3 from p1, one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dq_oe  <= 1'b0;
      dq_out <= '0;
    end else begin
      vld_p0 <= rd_vld;
      vld_p1 <= vld_p0;
      dq_oe  <= out_vld;
      if (out_vld) dq_out <= out_data;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, CL2/CL3 reads, byte masks, protocol errors, reset mid-read.
module tb_sdram_responder;

  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [12:0] a = '0;
  logic [1:0]  ba = '0;
  logic [1:0]  dm = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        init_done;
  logic [7:0]  refresh_count;
  logic        err;
  logic [2:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_responder dut (
    .clk(clk), .reset(reset), .cke(cke),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .a(a), .ba(ba), .dm(dm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done),
    .refresh_count(refresh_count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                      input logic [1:0] m, input logic [15:0] d);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; a = ad; dm = m; dq_in = d;
    @(posedge clk);
    #1;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    dm = 2'b00;
  endtask

  task automatic nop();
    step(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_oe", 16'(dq_oe), 16'h0);
    chk("rst_dq_out", dq_out, 16'h0000);
    chk("rst_init", 16'(init_done), 16'h0);
    chk("rst_refcnt", 16'(refresh_count), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_code", 16'(err_code), 16'h0);
    reset = 1'b0;

    // Init: precharge-all, two refreshes, MRS CL2
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    chk("init_pall", 16'(init_done), 16'h0);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("init_ref1_cnt", 16'(refresh_count), 16'h1);
    chk("init_ref1_done", 16'(init_done), 16'h0);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("init_ref2_cnt", 16'(refresh_count), 16'h2);
    chk("init_ref2_done", 16'(init_done), 16'h1);
    step(C_MRS, 2'd0, 13'h0020, 2'b00, 16'h0);
    chk("init_err", 16'(err), 16'h0);

    // Write / read at CL2
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    step(C_WR,  2'd1, 13'h0012, 2'b00, 16'hBEEF);
    step(C_PRE, 2'd1, 13'h0000, 2'b00, 16'h0);
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    step(C_RD,  2'd1, 13'h0012, 2'b00, 16'h0);
    chk("cl2_oe_n", 16'(dq_oe), 16'h0);
    nop();
    chk("cl2_oe_n1", 16'(dq_oe), 16'h1);
    chk("cl2_data", dq_out, 16'hBEEF);
    nop();
    chk("cl2_oe_n2", 16'(dq_oe), 16'h0);
    chk("cl2_err", 16'(err), 16'h0);

    // Byte mask, then CL3
    step(C_WR, 2'd1, 13'h0020, 2'b00, 16'h1234);
    step(C_WR, 2'd1, 13'h0020, 2'b01, 16'hABCD);
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    step(C_MRS, 2'd0, 13'h0030, 2'b00, 16'h0);
    chk("cl3_mrs_err", 16'(err), 16'h0);
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    step(C_RD,  2'd1, 13'h0020, 2'b00, 16'h0);
    chk("cl3_oe_n", 16'(dq_oe), 16'h0);
    nop();
    chk("cl3_oe_n1", 16'(dq_oe), 16'h0);
    nop();
    chk("cl3_oe_n2", 16'(dq_oe), 16'h1);
    chk("mask_data", dq_out, 16'hAB34);
    nop();
    chk("cl3_oe_n3", 16'(dq_oe), 16'h0);

    // Back-to-back reads at CL3
    step(C_WR, 2'd1, 13'h0000, 2'b00, 16'h0001);
    step(C_WR, 2'd1, 13'h0001, 2'b00, 16'h0002);
    step(C_WR, 2'd1, 13'h0002, 2'b00, 16'h0003);
    step(C_RD, 2'd1, 13'h0000, 2'b00, 16'h0);
    step(C_RD, 2'd1, 13'h0001, 2'b00, 16'h0);
    step(C_RD, 2'd1, 13'h0002, 2'b00, 16'h0);
    chk("b2b_oe0", 16'(dq_oe), 16'h1);
    chk("b2b_d0", dq_out, 16'h0001);
    nop();
    chk("b2b_oe1", 16'(dq_oe), 16'h1);
    chk("b2b_d1", dq_out, 16'h0002);
    nop();
    chk("b2b_oe2", 16'(dq_oe), 16'h1);
    chk("b2b_d2", dq_out, 16'h0003);
    nop();
    chk("b2b_oe3", 16'(dq_oe), 16'h0);
    chk("b2b_err", 16'(err), 16'h0);

    // Read with auto-precharge, then read to the now-closed bank
    step(C_RD, 2'd1, 13'h0400, 2'b00, 16'h0);
    nop();
    nop();
    chk("ap_oe", 16'(dq_oe), 16'h1);
    chk("ap_data", dq_out, 16'h0001);
    nop();
    step(C_RD, 2'd1, 13'h0000, 2'b00, 16'h0);
    chk("closed_err", 16'(err), 16'h1);
    chk("closed_code", 16'(err_code), 16'h2);
    nop();
    nop();
    chk("closed_oe", 16'(dq_oe), 16'h0);

    // Double activate, refresh with open bank
    step(C_ACT, 2'd2, 13'h0005, 2'b00, 16'h0);
    step(C_ACT, 2'd2, 13'h0006, 2'b00, 16'h0);
    chk("dblact_code", 16'(err_code), 16'h1);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("refopen_code", 16'(err_code), 16'h3);
    chk("refopen_cnt", 16'(refresh_count), 16'h2);

    // Write while a read is in flight: contention, write still lands
    step(C_RD, 2'd2, 13'h0000, 2'b00, 16'h0);
    step(C_WR, 2'd2, 13'h0001, 2'b00, 16'h5A5A);
    chk("bus_code", 16'(err_code), 16'h5);
    nop();
    nop();
    nop();
    step(C_RD, 2'd2, 13'h0001, 2'b00, 16'h0);
    nop();
    nop();
    chk("bus_wr_oe", 16'(dq_oe), 16'h1);
    chk("bus_wr_data", dq_out, 16'h5A5A);
    nop();

    // Bad CAS latency
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    step(C_MRS, 2'd0, 13'h0050, 2'b00, 16'h0);
    chk("badmode_code", 16'(err_code), 16'h4);

    // Reset the cycle after a READ
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    step(C_RD,  2'd1, 13'h0012, 2'b00, 16'h0);
    reset = 1'b1;
    nop();
    chk("rr_oe1", 16'(dq_oe), 16'h0);
    chk("rr_init", 16'(init_done), 16'h0);
    chk("rr_refcnt", 16'(refresh_count), 16'h0);
    chk("rr_err", 16'(err), 16'h0);
    chk("rr_code", 16'(err_code), 16'h0);
    reset = 1'b0;
    nop();
    chk("rr_oe2", 16'(dq_oe), 16'h0);
    nop();
    chk("rr_oe3", 16'(dq_oe), 16'h0);

    // Access before init is ignored; refresh proves banks were closed
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    chk("preinit_err", 16'(err), 16'h1);
    chk("preinit_code", 16'(err_code), 16'h6);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("closed_ref_cnt", 16'(refresh_count), 16'h1);
    chk("closed_ref_code", 16'(err_code), 16'h6);
    step(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("reinit_ref1", 16'(init_done), 16'h0);
    step(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
    chk("reinit_ref2", 16'(init_done), 16'h1);
    chk("reinit_cnt", 16'(refresh_count), 16'h3);

    // Memory retained; CL back to 2 without MRS
    step(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    step(C_RD,  2'd1, 13'h0012, 2'b00, 16'h0);
    nop();
    chk("keep_oe", 16'(dq_oe), 16'h1);
    chk("keep_data", dq_out, 16'hBEEF);
    chk("keep_code", 16'(err_code), 16'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
